// File: rtl/spy_bus_master_if.sv
// spy_bus_master_if: host request/response handshake plus the spy-port bus.
//   Host side : req_valid/req_ready/req_write/req_addr/req_wdata,
//               rsp_valid/rsp_ready/rsp_rdata/rsp_err
//   Spy side  : spy_sel (one-hot read selects), dbread, dbwrite,
//               spy_wdata, ld_sel (one-hot load strobes), spy_in (read mux)
// Modports: master = the spy bus initiator, slave = host + processor side.
interface spy_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [21:0] spy_sel;
  logic        dbread;
  logic        dbwrite;
  logic [15:0] spy_wdata;
  logic [7:0]  ld_sel;
  logic [15:0] spy_in;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, spy_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           spy_sel, dbread, dbwrite, spy_wdata, ld_sel
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, spy_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           spy_sel, dbread, dbwrite, spy_wdata, ld_sel
  );
endinterface

// File: rtl/spy_bus_master.sv
// spy_bus_master: host-side initiator for the CADR spy port.
// Accepts one read/write request at a time and runs a timed bus cycle:
//   SETUP (selects/data stable) -> STROBE (load strobe / read sample window)
//   -> HOLD (write data held, selects dropped) -> RESP (wait for rsp_ready).
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   bus      - spy_bus_master_if.master (request/response + spy bus)
// All bus outputs are registered; they are decoded from the next state so
// they line up with the state they belong to.
module spy_bus_master #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic clk,
  input  logic reset_n,
  spy_bus_master_if.master bus
);

  localparam int MAXC = (SETUP_CYCLES > STROBE_CYCLES)
                      ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                      : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [4:0]      addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            accept, capture;

  // next-cycle output values
  logic            req_ready_d, rsp_valid_d, rsp_err_d, dbread_d, dbwrite_d;
  logic [21:0]     spy_sel_d;
  logic [7:0]      ld_sel_d;
  logic [15:0]     spy_wdata_d;

  // output registers
  logic            req_ready_q, rsp_valid_q, rsp_err_q, dbread_q, dbwrite_q;
  logic [21:0]     spy_sel_q;
  logic [7:0]      ld_sel_q;
  logic [15:0]     spy_wdata_q, rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        accept  = 1'b1;
        wr_d    = bus.req_write;
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        state_d = SETUP;
        cnt_d   = CW'(SETUP_CYCLES - 1);
      end
      SETUP: if (cnt_q == '0) begin
        state_d = STROBE;
        cnt_d   = CW'(STROBE_CYCLES - 1);
      end else cnt_d = cnt_q - CW'(1);
      STROBE: if (cnt_q == '0) begin
        capture = !wr_q;             // sample spy_in on the last strobe cycle
        state_d = HOLD;
        cnt_d   = CW'(HOLD_CYCLES - 1);
      end else cnt_d = cnt_q - CW'(1);
      HOLD: if (cnt_q == '0) begin
        state_d = RESP;
        cnt_d   = '0;
      end else cnt_d = cnt_q - CW'(1);
      RESP: if (bus.rsp_ready) state_d = IDLE;  // rsp_valid is high in RESP
      default: state_d = IDLE;
    endcase

    // decode outputs for the state we are about to enter
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_err_d   = (state_d == RESP) && wr_d && (addr_d > 5'd7);
    dbread_d    = !wr_d && (state_d == SETUP || state_d == STROBE);
    dbwrite_d   =  wr_d && (state_d == SETUP || state_d == STROBE || state_d == HOLD);
    spy_sel_d   = (dbread_d && addr_d < 5'd22) ? (22'(1) << addr_d) : '0;
    ld_sel_d    = (wr_d && state_d == STROBE && addr_d < 5'd8) ? (8'(1) << addr_d[2:0]) : '0;
    spy_wdata_d = dbwrite_d ? wdata_d : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      dbread_q    <= 1'b0;
      dbwrite_q   <= 1'b0;
      spy_sel_q   <= '0;
      ld_sel_q    <= '0;
      spy_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      dbread_q    <= dbread_d;
      dbwrite_q   <= dbwrite_d;
      spy_sel_q   <= spy_sel_d;
      ld_sel_q    <= ld_sel_d;
      spy_wdata_q <= spy_wdata_d;
      // writes report 0; reads overwrite with the captured word
      if (accept)       rdata_q <= '0;
      else if (capture) rdata_q <= bus.spy_in;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.dbread    = dbread_q;
  assign bus.dbwrite   = dbwrite_q;
  assign bus.spy_sel   = spy_sel_q;
  assign bus.ld_sel    = ld_sel_q;
  assign bus.spy_wdata = spy_wdata_q;

endmodule

// File: tb/tb_spy_bus_master.sv
// Directed, table-driven bench for spy_bus_master at default timing (2/4/2).
module tb_spy_bus_master;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spy_bus_master_if bif();

  spy_bus_master #(.SETUP_CYCLES(2), .STROBE_CYCLES(4), .HOLD_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bif)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] spy;
    logic [21:0] e_sel;
    int          e_nrd;
    int          e_nwr;
    logic [7:0]  e_ld;
    int          e_nld;
    logic [15:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[7];
  int checks = 0;
  int errors = 0;

  // per-transaction observations
  int n_rd, n_wr, n_ld, first_wr, first_ld, lat;
  logic [21:0] sel_or;
  logic [7:0]  ld_or;
  bit wd_ok;
  bit saw_rsp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // present a request in IDLE; it is accepted at the next rising edge,
  // after which the request lines carry garbage that must be ignored
  task automatic send(input logic wr, input logic [4:0] addr, input logic [15:0] wd);
    @(posedge clk); #1;
    chk("req_ready_idle", bif.req_ready, 1);
    bif.req_valid = 1'b1;
    bif.req_write = wr;
    bif.req_addr  = addr;
    bif.req_wdata = wd;
    @(posedge clk); #1;
    bif.req_valid = 1'b0;
    bif.req_write = ~wr;
    bif.req_addr  = ~addr;
    bif.req_wdata = ~wd;
  endtask

  // sample every falling edge until rsp_valid (cycle k=1 is the first after acceptance)
  task automatic observe(input logic [15:0] wd);
    n_rd = 0; n_wr = 0; n_ld = 0; first_wr = -1; first_ld = -1; lat = -1;
    sel_or = '0; ld_or = '0; wd_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk("inv_sel_onehot0", $onehot0(bif.spy_sel), 1);
      chk("inv_ld_onehot0", $onehot0(bif.ld_sel), 1);
      chk("inv_rd_and_wr", bif.dbread & bif.dbwrite, 0);
      if (bif.dbread) begin n_rd++; sel_or |= bif.spy_sel; end
      else if (bif.spy_sel != '0) sel_or |= bif.spy_sel;
      if (bif.dbwrite) begin
        n_wr++;
        if (first_wr < 0) first_wr = k;
        if (bif.spy_wdata !== wd) wd_ok = 1'b0;
      end
      if (bif.ld_sel != '0) begin
        n_ld++;
        ld_or |= bif.ld_sel;
        if (first_ld < 0) first_ld = k;
      end
      if (bif.rsp_valid) begin lat = k; break; end
    end
    if (lat < 0) chk("rsp_timeout", 0, 1);
  endtask

  initial begin
    //            wr    addr   wdata     spy_in    e_sel        rd wr e_ld   nld e_rdata   e_err
    vecs[0] = '{1'b0, 5'd20, 16'h0000, 16'h1234, 22'h100000, 6, 0, 8'h00, 0, 16'h1234, 1'b0};
    vecs[1] = '{1'b1, 5'd3,  16'h0ABC, 16'hDEAD, 22'h000000, 0, 8, 8'h08, 4, 16'h0000, 1'b0};
    vecs[2] = '{1'b1, 5'd12, 16'h4321, 16'hBEEF, 22'h000000, 0, 8, 8'h00, 0, 16'h0000, 1'b1};
    vecs[3] = '{1'b0, 5'd25, 16'h0000, 16'hFFFF, 22'h000000, 6, 0, 8'h00, 0, 16'hFFFF, 1'b0};
    vecs[4] = '{1'b0, 5'd0,  16'h0000, 16'hA5A5, 22'h000001, 6, 0, 8'h00, 0, 16'hA5A5, 1'b0};
    vecs[5] = '{1'b1, 5'd7,  16'h8001, 16'h0000, 22'h000000, 0, 8, 8'h80, 4, 16'h0000, 1'b0};
    vecs[6] = '{1'b0, 5'd21, 16'h0000, 16'h0F0F, 22'h200000, 6, 0, 8'h00, 0, 16'h0F0F, 1'b0};

    bif.req_valid = 1'b0; bif.req_write = 1'b0; bif.req_addr = '0; bif.req_wdata = '0;
    bif.rsp_ready = 1'b0; bif.spy_in = '0;

    // reset state
    #12;
    chk("rst_req_ready", bif.req_ready, 1);
    chk("rst_rsp_valid", bif.rsp_valid, 0);
    chk("rst_spy_sel", bif.spy_sel, 0);
    chk("rst_dbread", bif.dbread, 0);
    chk("rst_dbwrite", bif.dbwrite, 0);
    chk("rst_ld_sel", bif.ld_sel, 0);
    @(negedge clk) reset_n = 1'b1;

    // table-driven transactions, host always ready for the response
    for (int i = 0; i < 7; i++) begin
      bif.spy_in = vecs[i].spy;
      bif.rsp_ready = 1'b1;
      send(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      observe(vecs[i].wdata);
      chk("spy_sel", sel_or, vecs[i].e_sel);
      chk("dbread_cycles", n_rd, vecs[i].e_nrd);
      chk("dbwrite_cycles", n_wr, vecs[i].e_nwr);
      chk("ld_sel", ld_or, vecs[i].e_ld);
      chk("ld_cycles", n_ld, vecs[i].e_nld);
      chk("rsp_latency", lat, 9);
      chk("rsp_rdata", bif.rsp_rdata, vecs[i].e_rdata);
      chk("rsp_err", bif.rsp_err, vecs[i].e_err);
      chk("spy_wdata", wd_ok, 1);
      if (vecs[i].e_nld > 0) chk("ld_offset", first_ld - first_wr, 2);
      @(negedge clk);
      chk("rsp_drop", bif.rsp_valid, 0);
      chk("back_to_idle", bif.req_ready, 1);
    end

    // response back-pressure with a second request waiting
    bif.rsp_ready = 1'b0;
    bif.spy_in = 16'h5555;
    send(1'b0, 5'd5, 16'h0000);
    observe(16'h0000);
    chk("bp_latency", lat, 9);
    bif.req_valid = 1'b1; bif.req_write = 1'b1; bif.req_addr = 5'd1; bif.req_wdata = 16'h2222;
    bif.spy_in = 16'h0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", bif.rsp_valid, 1);
      chk("bp_rsp_rdata", bif.rsp_rdata, 16'h5555);
      chk("bp_req_ready", bif.req_ready, 0);
      chk("bp_no_write", bif.dbwrite, 0);
    end
    bif.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rsp_done", bif.rsp_valid, 0);
    chk("bp_idle_ready", bif.req_ready, 1);
    chk("bp_not_yet", bif.dbwrite, 0);
    @(negedge clk);
    chk("bp_second_accept", bif.dbwrite, 1);
    chk("bp_second_busy", bif.req_ready, 0);
    chk("bp_second_wdata", bif.spy_wdata, 16'h2222);
    bif.req_valid = 1'b0;
    observe(16'h2222);
    chk("bp_second_ld", ld_or, 8'h02);
    chk("bp_second_nld", n_ld, 4);
    chk("bp_second_err", bif.rsp_err, 0);
    chk("bp_second_rdata", bif.rsp_rdata, 0);
    @(negedge clk);

    // asynchronous reset in the middle of a write strobe
    send(1'b1, 5'd2, 16'h1357);
    repeat (4) @(negedge clk);
    chk("rst_mid_ld_before", bif.ld_sel, 8'h04);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_ld_sel", bif.ld_sel, 0);
    chk("rst_mid_dbwrite", bif.dbwrite, 0);
    chk("rst_mid_spy_wdata", bif.spy_wdata, 0);
    chk("rst_mid_req_ready", bif.req_ready, 1);
    @(negedge clk) reset_n = 1'b1;
    saw_rsp = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bif.rsp_valid || bif.dbwrite) saw_rsp = 1'b1;
    end
    chk("rst_no_rsp", saw_rsp, 0);
    chk("rst_after_ready", bif.req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spy_bus_master.md
Name: spy_bus_master

Overview:
- Host-side initiator for the CADR spy port.
- Accepts single-word read/write requests from a debug front end (serial or unibus bridge) over a valid/ready handshake.
- Reads: decodes a 5-bit spy address into one-hot read selects, asserts dbread, captures the 16-bit spy data word.
- Writes: drives write data and a timed one-hot load strobe.
- Sits between the debug interface logic and the processor's spy read mux and spy load registers.

Parameters:
SETUP_CYCLES, 2, cycles selects/data are stable before capture or strobe (min 1)
STROBE_CYCLES, 4, cycles of the strobe window; read data sampled in its last cycle (min 1)
HOLD_CYCLES, 2, cycles data/dbwrite held after the strobe drops (min 1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  host request present
req_ready  out  1  master can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  5  spy address
req_wdata  in  16  write data
rsp_valid  out  1  response available
rsp_ready  in  1  host accepts response
rsp_rdata  out  16  read data (0 for writes)
rsp_err  out  1  write to unmapped address
spy_sel  out  22  one-hot read selects
dbread  out  1  spy read enable
dbwrite  out  1  spy write cycle active
spy_wdata  out  16  data driven to spy load registers
ld_sel  out  8  one-hot load strobes
spy_in  in  16  spy mux output

Behaviour:
- Reset (async, immediate): state IDLE, req_ready=1, all other outputs 0. Any in-flight strobe or select drops at once. No response is generated for an aborted request.
- States: IDLE, SETUP, STROBE, HOLD, RESP. A down-counter loads N-1 on entry to each timed phase and advances when it reaches 0.
- IDLE:
  - req_ready=1.
  - On req_valid: latch write, addr, wdata; go to SETUP next cycle.
  - Accepted request = req_valid && req_ready.
- Read cycle:
  - SETUP through STROBE: spy_sel[addr]=1 for addr 0..21 (0 irh, 1 irm, 2 irl, 3 obh, 4 obl, 5 obh_, 6 obl_, 7 disk, 8 bd, 9 ah, 10 al, 11 mh, 12 ml, 13 mdh, 14 mdl, 15 vmah, 16 vmal, 17 flag2, 18 opc, 19 flag1, 20 pc, 21 scratch); dbread=1.
  - Addr 22..31: no select asserted, but the bus cycle still runs and dbread is asserted.
  - spy_in is registered into rsp_rdata on the final STROBE cycle.
  - HOLD: spy_sel=0, dbread=0.
  - rsp_err=0.
- Write cycle:
  - dbwrite=1 and spy_wdata=wdata from SETUP through HOLD.
  - ld_sel[addr] is asserted only during STROBE, for addr 0..7: 0 lddbirh, 1 lddbirm, 2 lddbirl, 3 ldopc, 4 ldmode, 5 ldscratch1, 6 ldscratch2, 7 ldclk.
  - Addr 8..31: no strobe, and rsp_err=1 in RESP.
  - rsp_rdata=0.
- Latency: a read's rsp_valid first asserts SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES+1 cycles after acceptance (9 at defaults).
- RESP:
  - rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE; rsp_valid drops next cycle.
  - rsp_ready without rsp_valid is ignored.
- Requests are not pipelined; req_ready=0 in every non-IDLE state.
- Invariants:
  - At most one bit of spy_sel is set.
  - At most one bit of ld_sel is set.
  - dbread and dbwrite are never both 1.
  - Outputs are registered (no combinational path from req_* to spy_*).
- Request fields are latched at acceptance; changes on req_* during a cycle have no effect.

Test Plan:
- Read addr 20 with spy_in=16'h1234, rsp_ready=1 → spy_sel=22'h100000 and dbread=1 for 6 cycles; rsp_rdata=16'h1234, rsp_err=0, rsp_valid high 9 cycles after acceptance.
- Write addr 3, wdata 16'h0ABC → dbwrite=1 for 8 cycles; ld_sel=8'h08 for exactly 4 cycles starting 2 cycles after dbwrite rises; spy_wdata=16'h0ABC throughout; response rsp_err=0, rsp_rdata=0.
- Write addr 12 → no ld_sel bit ever set; rsp_err=1.
- Read addr 25 with spy_in=16'hFFFF → spy_sel stays 0, dbread still pulses; rsp_rdata=16'hFFFF.
- Hold rsp_ready=0 for 5 cycles in RESP while req_valid=1 → rsp_valid and data stable, req_ready=0, second request not accepted until after the rsp handshake.
- Assert reset_n=0 mid-STROBE of a write → ld_sel, dbwrite, spy_wdata go to 0 without a clock edge; after release, req_ready=1 and no rsp_valid appears.
